// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR parity generator: update-form enum,
// default polynomial/seed constants and the parity helper.
package lfsr_pkg;

    // Update form of the shift register.
    typedef enum logic {
        FIB = 1'b0,
        GAL = 1'b1
    } lfsr_mode_e;

    // Default feedback mask (x^7 + x^6 + 1) and seed, kept 32 bits wide
    // so any legal WIDTH can slice them.
    localparam logic [31:0] DEFAULT_TAPS = 32'h0000_0060;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    // Even parity of a zero-extended value (zero padding leaves the XOR unchanged).
    function automatic logic even_parity(input logic [31:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function of the LFSR, in Fibonacci or Galois form.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS[WIDTH-1:0],
    parameter lfsr_mode_e       MODE  = FIB
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    // Select the update form; Fibonacci shifts the tap XOR in at the bottom,
    // Galois shifts right and folds the mask in when the bit leaving is set.
    always_comb begin
        next_state = state;
        case (MODE)
            FIB:     next_state = {state[WIDTH-2:0], ^(state & TAPS)};
            GAL:     next_state = (state >> 1'b1) ^ ({WIDTH{state[0]}} & TAPS);
            default: next_state = state;
        endcase
    end

endmodule

// File: rtl/lfsr_parity_gen.sv
// LFSR with registered even-parity output, step counter, wrap detection
// against a loadable seed register, and optional all-zero lockup recovery.
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN (recover all-zero state to SEED).
module lfsr_parity_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS[WIDTH-1:0],
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED[WIDTH-1:0],
    parameter lfsr_mode_e       MODE  = FIB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH:0]   lfsr_out,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             lockup
);

    // Registered state: lfsr_out_r holds {parity, state} so both update together.
    logic [WIDTH:0]   lfsr_out_r;
    logic [WIDTH-1:0] seed_r;
    logic [WIDTH-1:0] cnt_r;
    logic             wrap_r;
    logic             lockup_r;

    logic [WIDTH-1:0] state_s;
    logic [WIDTH-1:0] adv_state_s;
    logic             advance_s;
    logic             recover_s;
    logic [WIDTH-1:0] nxt_state_s;
    logic [WIDTH-1:0] nxt_seed_s;
    logic [WIDTH-1:0] nxt_cnt_s;
    logic             nxt_wrap_s;
    logic             nxt_lockup_s;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    assign state_s   = lfsr_out_r[WIDTH-1:0];
    // en and step together still produce a single advance.
    assign advance_s = (en | step) & ~load;

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign recover_s = (state_s == ZERO_W);
`else
    assign recover_s = 1'b0;
`endif

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_lfsr_next (
        .state      (state_s),
        .next_state (adv_state_s)
    );

    // Next-state decision: load beats advance; recovery beats normal stepping.
    always_comb begin
        nxt_state_s  = state_s;
        nxt_seed_s   = seed_r;
        nxt_cnt_s    = cnt_r;
        nxt_wrap_s   = 1'b0;
        nxt_lockup_s = 1'b0;
        if (load) begin
            nxt_state_s = seed_in;
            nxt_seed_s  = seed_in;
            nxt_cnt_s   = ZERO_W;
        end else if (advance_s) begin
            if (recover_s) begin
                // All-zero state cannot escape on its own; restart from SEED.
                nxt_state_s  = SEED;
                nxt_seed_s   = SEED;
                nxt_cnt_s    = ZERO_W;
                nxt_lockup_s = 1'b1;
            end else if (adv_state_s == seed_r) begin
                nxt_state_s = adv_state_s;
                nxt_cnt_s   = ZERO_W;
                nxt_wrap_s  = 1'b1;
            end else begin
                nxt_state_s = adv_state_s;
                nxt_cnt_s   = cnt_r + ONE_W;
            end
        end else begin
            nxt_state_s = state_s;
            nxt_cnt_s   = cnt_r;
        end
    end

    // State, seed, counter and pulse registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_out_r <= {even_parity(32'(SEED)), SEED};
            seed_r     <= SEED;
            cnt_r      <= ZERO_W;
            wrap_r     <= 1'b0;
            lockup_r   <= 1'b0;
        end else begin
            lfsr_out_r <= {even_parity(32'(nxt_state_s)), nxt_state_s};
            seed_r     <= nxt_seed_s;
            cnt_r      <= nxt_cnt_s;
            wrap_r     <= nxt_wrap_s;
            lockup_r   <= nxt_lockup_s;
        end
    end

    assign lfsr_out = lfsr_out_r;
    assign cnt      = cnt_r;
    assign wrap     = wrap_r;
    assign lockup   = lockup_r;

endmodule

// File: tb/tb_lfsr_parity_gen.sv
// Self-checking bench for lfsr_parity_gen with default parameters.
// Honours LFSR_LOCKUP_RECOVER_EN to match the build of the design.
module tb_lfsr_parity_gen;

    localparam logic [6:0] TB_TAPS = 7'h60;
    localparam logic [6:0] TB_SEED = 7'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       step = 1'b0;
    logic       load = 1'b0;
    logic [6:0] seed_in = 7'h00;
    logic [7:0] lfsr_out;
    logic [6:0] cnt;
    logic       wrap;
    logic       lockup;

    int checks = 0;
    int errors = 0;

    lfsr_parity_gen dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .step     (step),
        .load     (load),
        .seed_in  (seed_in),
        .lfsr_out (lfsr_out),
        .cnt      (cnt),
        .wrap     (wrap),
        .lockup   (lockup)
    );

    always #5 clk = ~clk;

    // Reference model: state as an integer, next state from the polynomial
    // definition (shift left, feedback = parity of tapped bits).
    int  m_state = 0;
    int  m_seed  = 0;
    int  m_cnt   = 0;
    bit  m_wrap  = 1'b0;
    bit  m_lock  = 1'b0;
    bit  m_valid = 1'b0;

    function automatic int poly_next(input int s);
        int fb;
        fb = $countones(s & int'(TB_TAPS)) % 2;
        return ((s * 2) % 128) + fb;
    endfunction

    function automatic int exp_out(input int s);
        return (($countones(s) % 2) * 128) + s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the inputs the DUT sees.
    always @(posedge clk) begin
        int n;
        if (!rst) begin
            m_state = int'(TB_SEED); m_seed = int'(TB_SEED); m_cnt = 0;
            m_wrap = 1'b0; m_lock = 1'b0; m_valid = 1'b1;
        end else if (load) begin
            m_state = int'(seed_in); m_seed = int'(seed_in); m_cnt = 0;
            m_wrap = 1'b0; m_lock = 1'b0;
        end else if (en || step) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (m_state == 0) begin
                m_state = int'(TB_SEED); m_seed = int'(TB_SEED); m_cnt = 0;
                m_wrap = 1'b0; m_lock = 1'b1;
            end else begin
`else
            begin
`endif
                n = poly_next(m_state);
                m_wrap = (n == m_seed);
                m_cnt  = m_wrap ? 0 : (m_cnt + 1) % 128;
                m_state = n;
                m_lock = 1'b0;
            end
        end else begin
            m_wrap = 1'b0; m_lock = 1'b0;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_out",    int'(lfsr_out), exp_out(m_state));
            chk("model_cnt",    int'(cnt),      m_cnt);
            chk("model_wrap",   int'(wrap),     int'(m_wrap));
            chk("model_lockup", int'(lockup),   int'(m_lock));
        end
    end

    // Drive one cycle of inputs, then sample #1 after the edge.
    task automatic tick(input logic e, input logic s, input logic l,
                        input logic r, input logic [6:0] d);
        en = e; step = s; load = l; rst = r; seed_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit early;

        // Reset values.
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        chk("reset_out", int'(lfsr_out), 8'h81);
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_lockup", int'(lockup), 0);

        // First enabled step.
        tick(1'b1, 1'b0, 1'b0, 1'b1, 7'h00);
        chk("en1_out", int'(lfsr_out), 8'h82);
        chk("en1_cnt", int'(cnt), 1);

        // Full period from reset.
        tick(1'b0, 1'b0, 1'b0, 1'b0, 7'h00);
        early = 1'b0;
        for (int i = 1; i <= 127; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1, 7'h00);
            if (i < 127) begin
                if (wrap || lfsr_out[6:0] == 7'h01) early = 1'b1;
            end
        end
        chk("period_wrap", int'(wrap), 1);
        chk("period_state", int'(lfsr_out[6:0]), 7'h01);
        chk("period_cnt", int'(cnt), 0);
        chk("period_no_early_repeat", int'(early), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 7'h00);
        chk("idle_wrap_low", int'(wrap), 0);
        chk("idle_hold_out", int'(lfsr_out), 8'h81);

        // Single step, then en with step counts once.
        tick(1'b0, 1'b1, 1'b0, 1'b1, 7'h00);
        chk("step_out", int'(lfsr_out), 8'h82);
        chk("step_cnt", int'(cnt), 1);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 7'h00);
        chk("en_step_out", int'(lfsr_out), 8'h84);
        chk("en_step_cnt", int'(cnt), 2);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 7'h00);
        chk("hold_out", int'(lfsr_out), 8'h84);
        chk("hold_cnt", int'(cnt), 2);

        // Load beats en; wrap back to the loaded seed after 127 steps.
        tick(1'b1, 1'b0, 1'b1, 1'b1, 7'h55);
        chk("load_out", int'(lfsr_out), 8'h55);
        chk("load_cnt", int'(cnt), 0);
        early = 1'b0;
        for (int i = 1; i <= 127; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1, 7'h00);
            if (i < 127) begin
                if (wrap || lfsr_out[6:0] == 7'h55) early = 1'b1;
            end
        end
        chk("load_wrap", int'(wrap), 1);
        chk("load_wrap_state", int'(lfsr_out[6:0]), 7'h55);
        chk("load_no_early_repeat", int'(early), 0);

        // All-zero load.
        tick(1'b1, 1'b0, 1'b1, 1'b1, 7'h00);
        chk("zero_load_out", int'(lfsr_out), 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 7'h00);
`ifdef LFSR_LOCKUP_RECOVER_EN
        chk("recover_out", int'(lfsr_out), 8'h81);
        chk("recover_lockup", int'(lockup), 1);
        chk("recover_cnt", int'(cnt), 0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 7'h00);
        chk("recover_next_out", int'(lfsr_out), 8'h82);
        chk("recover_lockup_drop", int'(lockup), 0);
`else
        chk("stuck_out", int'(lfsr_out), 8'h00);
        chk("stuck_lockup", int'(lockup), 0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 7'h00);
        chk("stuck_out2", int'(lfsr_out), 8'h00);
`endif

        // Reset mid-run wins over load and en.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 7'h00);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 7'h33);
        chk("midrun_reset_out", int'(lfsr_out), 8'h81);
        chk("midrun_reset_cnt", int'(cnt), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r, l, e, s;
            logic [6:0] d;
            r = ($urandom_range(0, 199) != 0);
            l = ($urandom_range(0, 19) == 0);
            e = $urandom_range(0, 1) != 0;
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom);
            tick(e, s, l, r, d);
        end

        tick(1'b0, 1'b0, 1'b0, 1'b1, 7'h00);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
